// File: rtl/control_multiciclo_pkg.sv
// Shared constants for the multicycle control unit and the ALU:
// state codes, opcodes, funct codes, ALU select codes and ALU-op classes.
package control_multiciclo_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_OR  = 3'b001;
    localparam logic [2:0] SEL_ADD = 3'b010;
    localparam logic [2:0] SEL_SUB = 3'b110;
    localparam logic [2:0] SEL_SLT = 3'b111;
    localparam logic [2:0] SEL_NOR = 3'b100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/decodificador_alu.sv
// ALU select decoder: fixed ADD/SUB classes or a FUNCT-field decode,
// flagging FUNCT values the ALU does not implement.
module decodificador_alu
    import control_multiciclo_pkg::*;
(
    input  logic [1:0] ALUOP,
    input  logic [5:0] FUNCT,
    output logic [2:0] SEL,
    output logic       INVALIDO
);

    // Map ALU-op class and FUNCT to a select code; unknown FUNCT falls back to ADD
    always_comb begin
        SEL      = SEL_ADD;
        INVALIDO = 1'b0;
        case (ALUOP)
            ALUOP_SUB:   SEL = SEL_SUB;
            ALUOP_FUNCT: begin
                case (FUNCT)
                    FN_AND:  SEL = SEL_AND;
                    FN_OR:   SEL = SEL_OR;
                    FN_ADD:  SEL = SEL_ADD;
                    FN_SUB:  SEL = SEL_SUB;
                    FN_SLT:  SEL = SEL_SLT;
                    FN_NOR:  SEL = SEL_NOR;
                    default: INVALIDO = 1'b1;
                endcase
            end
            default:     SEL = SEL_ADD;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle MIPS-subset control unit: a single state register plus a
// Moore output decode (PCEN in BRANCH follows ZERO; FETCH enables follow MEMLISTO).
module control_multiciclo
    import control_multiciclo_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       ZERO,
    input  logic       MEMLISTO,
    output logic       PCEN,
    output logic       IORD,
    output logic       MEMWRITE,
    output logic       IRWRITE,
    output logic       REGDST,
    output logic       MEMTOREG,
    output logic       REGWRITE,
    output logic       ALUSRCA,
    output logic [1:0] ALUSRCB,
    output logic [1:0] PCSRC,
    output logic [2:0] SEL,
    output logic       ILEGAL,
    output logic [3:0] ESTADO
);

    state_t     estado_q;
    state_t     estado_d;
    logic [1:0] aluop;
    logic [2:0] sel_dec;
    logic       funct_inv;

    decodificador_alu u_dec (
        .ALUOP    (aluop),
        .FUNCT    (FUNCT),
        .SEL      (sel_dec),
        .INVALIDO (funct_inv)
    );

    assign ESTADO = estado_q;

    // State register; reset returns to FETCH from anywhere, including memory waits
    always_ff @(posedge CLK) begin
        if (RST) estado_q <= S_FETCH;
        else     estado_q <= estado_d;
    end

    // Next-state and output decode; reset shows a quiet FETCH (no loads, no ILEGAL)
    always_comb begin
        estado_d = S_FETCH;
        aluop    = ALUOP_ADD;
        PCEN     = 1'b0;
        IORD     = 1'b0;
        MEMWRITE = 1'b0;
        IRWRITE  = 1'b0;
        REGDST   = 1'b0;
        MEMTOREG = 1'b0;
        REGWRITE = 1'b0;
        ALUSRCA  = 1'b0;
        ALUSRCB  = 2'b00;
        PCSRC    = 2'b00;
        SEL      = 3'b000;
        ILEGAL   = 1'b0;
        if (RST) begin
            ALUSRCB = 2'b01;
            SEL     = sel_dec;
        end else begin
            case (estado_q)
                S_FETCH: begin
                    ALUSRCB  = 2'b01;
                    SEL      = sel_dec;
                    PCEN     = MEMLISTO;
                    IRWRITE  = MEMLISTO;
                    estado_d = MEMLISTO ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    ALUSRCB = 2'b10;
                    SEL     = sel_dec;
                    case (OPCODE)
                        OP_LW, OP_SW: estado_d = S_MEMADR;
                        OP_R:         estado_d = S_EXEC;
                        OP_BEQ:       estado_d = S_BRANCH;
                        OP_ADDI:      estado_d = S_ADDIEX;
                        OP_J:         estado_d = S_JUMP;
                        default:      ILEGAL   = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    ALUSRCA  = 1'b1;
                    ALUSRCB  = 2'b10;
                    SEL      = sel_dec;
                    estado_d = (OPCODE == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    IORD     = 1'b1;
                    estado_d = MEMLISTO ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    MEMTOREG = 1'b1;
                    REGWRITE = 1'b1;
                end
                S_MEMWR: begin
                    IORD     = 1'b1;
                    MEMWRITE = 1'b1;
                    estado_d = MEMLISTO ? S_FETCH : S_MEMWR;
                end
                S_EXEC: begin
                    ALUSRCA = 1'b1;
                    aluop   = ALUOP_FUNCT;
                    SEL     = sel_dec;
                    if (funct_inv) ILEGAL   = 1'b1;
                    else           estado_d = S_ALUWB;
                end
                S_ALUWB: begin
                    REGDST   = 1'b1;
                    REGWRITE = 1'b1;
                end
                S_BRANCH: begin
                    ALUSRCA = 1'b1;
                    aluop   = ALUOP_SUB;
                    SEL     = sel_dec;
                    PCSRC   = 2'b01;
                    PCEN    = ZERO;
                end
                S_ADDIEX: begin
                    ALUSRCA  = 1'b1;
                    ALUSRCB  = 2'b10;
                    SEL      = sel_dec;
                    estado_d = S_ADDIWB;
                end
                S_ADDIWB: REGWRITE = 1'b1;
                S_JUMP: begin
                    PCSRC = 2'b10;
                    PCEN  = 1'b1;
                end
                default: estado_d = S_FETCH;
            endcase
        end
    end

endmodule
